// File: rtl/axi_cmd_responder.sv
// Host command decoder: drives a word memory port and a string-matching engine, tracks run status and elapsed cycles.
// Optional run-time limit enabled by defining CMD_TIMEOUT_EN.
module axi_cmd_responder #(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_WIDTH-1:0]      cmd_register,
    input  logic [REG_WIDTH-1:0]      address_register,
    input  logic [REG_WIDTH-1:0]      data_in_register,
    input  logic [REG_WIDTH-1:0]      start_cc_pointer_register,
    input  logic [REG_WIDTH-1:0]      end_cc_pointer_register,
    output logic [REG_WIDTH-1:0]      status_register,
    output logic [REG_WIDTH-1:0]      data_o_register,
    output logic                      mem_we,
    output logic                      mem_re,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]      mem_wdata,
    input  logic [REG_WIDTH-1:0]      mem_rdata,
    output logic                      eng_start,
    output logic                      eng_abort,
    output logic [REG_WIDTH-1:0]      eng_start_ptr,
    output logic [REG_WIDTH-1:0]      eng_end_ptr,
    input  logic                      eng_done,
    input  logic                      eng_accept
);

    localparam logic [REG_WIDTH-1:0] CMD_WRITE   = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] CMD_READ    = REG_WIDTH'(2);
    localparam logic [REG_WIDTH-1:0] CMD_START   = REG_WIDTH'(3);
    localparam logic [REG_WIDTH-1:0] CMD_RESET   = REG_WIDTH'(4);
    localparam logic [REG_WIDTH-1:0] CMD_ELAPSED = REG_WIDTH'(5);
    localparam logic [REG_WIDTH-1:0] CNT_MAX     = '1;
`ifdef CMD_TIMEOUT_EN
    localparam logic [REG_WIDTH-1:0] TMO_LAST    = REG_WIDTH'(TIMEOUT_CYCLES - 1);
`endif

    // Encodings equal the status codes reported to the host
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUNNING  = 3'd1,
        ST_DONE_ACC = 3'd2,
        ST_DONE_REJ = 3'd3,
        ST_TIMEOUT  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [REG_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      start_seen_q;
    logic                      rd_pend_q;
    logic                      eng_start_d, eng_abort_d, mem_we_d, mem_re_d;
    logic [REG_WIDTH-1:0]      start_ptr_d, end_ptr_d, wdata_d, data_o_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_d;
    logic                      is_write, is_read, is_start, is_reset, is_elapsed;
    logic                      unused_addr_hi;

    assign is_write   = (cmd_register == CMD_WRITE);
    assign is_read    = (cmd_register == CMD_READ);
    assign is_start   = (cmd_register == CMD_START);
    assign is_reset   = (cmd_register == CMD_RESET);
    assign is_elapsed = (cmd_register == CMD_ELAPSED);

    assign unused_addr_hi  = ^address_register[REG_WIDTH-1:MEM_ADDR_WIDTH];
    assign status_register = REG_WIDTH'(state_q);

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        eng_start_d = 1'b0;
        eng_abort_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        start_ptr_d = eng_start_ptr;
        end_ptr_d   = eng_end_ptr;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        data_o_d    = data_o_register;

        // Memory answers one cycle after mem_re; an elapsed-clock read takes precedence
        if (rd_pend_q) begin
            data_o_d = mem_rdata;
        end
        if (is_elapsed) begin
            data_o_d = cnt_q;
        end

        if (is_reset) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            eng_abort_d = (state_q == ST_RUNNING);
        end else if (state_q == ST_RUNNING) begin
            // Counter reflects the number of cycles spent in RUNNING
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + REG_WIDTH'(1);
            end
            if (eng_done) begin
                state_d = eng_accept ? ST_DONE_ACC : ST_DONE_REJ;
            end
`ifdef CMD_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
                state_d     = ST_TIMEOUT;
                eng_abort_d = 1'b1;
            end
`endif
        end else begin
            if (is_start && !start_seen_q) begin
                state_d     = ST_RUNNING;
                eng_start_d = 1'b1;
                start_ptr_d = start_cc_pointer_register;
                end_ptr_d   = end_cc_pointer_register;
                cnt_d       = '0;
            end else if (is_write) begin
                mem_we_d = 1'b1;
                addr_d   = address_register[MEM_ADDR_WIDTH-1:0];
                wdata_d  = data_in_register;
            end else if (is_read) begin
                mem_re_d = 1'b1;
                addr_d   = address_register[MEM_ADDR_WIDTH-1:0];
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            start_seen_q    <= 1'b0;
            rd_pend_q       <= 1'b0;
            eng_start       <= 1'b0;
            eng_abort       <= 1'b0;
            eng_start_ptr   <= '0;
            eng_end_ptr     <= '0;
            mem_we          <= 1'b0;
            mem_re          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            data_o_register <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            start_seen_q    <= is_start;
            rd_pend_q       <= mem_re;
            eng_start       <= eng_start_d;
            eng_abort       <= eng_abort_d;
            eng_start_ptr   <= start_ptr_d;
            eng_end_ptr     <= end_ptr_d;
            mem_we          <= mem_we_d;
            mem_re          <= mem_re_d;
            mem_addr        <= addr_d;
            mem_wdata       <= wdata_d;
            data_o_register <= data_o_d;
        end
    end

endmodule

// File: tb/tb_axi_cmd_responder.sv
// Directed bench for axi_cmd_responder with a registered word-memory model.
// Timeout scenario is exercised when CMD_TIMEOUT_EN is defined.
module tb_axi_cmd_responder;

    localparam int unsigned RW = 32;
    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] cmd_register, address_register, data_in_register;
    logic [RW-1:0] start_cc_pointer_register, end_cc_pointer_register;
    logic [RW-1:0] status_register, data_o_register;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [RW-1:0] mem_wdata, mem_rdata;
    logic          eng_start, eng_abort, eng_done, eng_accept;
    logic [RW-1:0] eng_start_ptr, eng_end_ptr;

    int n_chk  = 0;
    int n_pass = 0;
    int start_pulses = 0;
    int abort_pulses = 0;
    int snap;

    logic [RW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    axi_cmd_responder #(
        .REG_WIDTH(RW), .MEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_register(cmd_register), .address_register(address_register),
        .data_in_register(data_in_register),
        .start_cc_pointer_register(start_cc_pointer_register),
        .end_cc_pointer_register(end_cc_pointer_register),
        .status_register(status_register), .data_o_register(data_o_register),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .eng_start(eng_start), .eng_abort(eng_abort),
        .eng_start_ptr(eng_start_ptr), .eng_end_ptr(eng_end_ptr),
        .eng_done(eng_done), .eng_accept(eng_accept)
    );

    // Memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (eng_start) start_pulses <= start_pulses + 1;
        if (eng_abort) abort_pulses <= abort_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        mem_rdata = '0;
        rst = 1'b0;
        cmd_register = 0; address_register = 0; data_in_register = 0;
        start_cc_pointer_register = 0; end_cc_pointer_register = 0;
        eng_done = 0; eng_accept = 0;
        steps(3);
        check("rst_status", status_register, 0);
        check("rst_data_o", data_o_register, 0);
        check("rst_we_re", {30'd0, mem_we, mem_re}, 0);
        check("rst_eng", {30'd0, eng_start, eng_abort}, 0);
        rst = 1'b1;
        step();

        // Held WRITE with changing address/data writes one word per cycle
        cmd_register = 1; address_register = 0; data_in_register = 32'hA;
        step();
        check("wr0", {mem_we, 19'd0, mem_addr}, {1'b1, 19'd0, 12'd0});
        check("wr0_data", mem_wdata, 32'hA);
        address_register = 1; data_in_register = 32'hB;
        step();
        check("wr1", {mem_we, 19'd0, mem_addr}, {1'b1, 19'd0, 12'd1});
        check("wr1_data", mem_wdata, 32'hB);
        address_register = 2; data_in_register = 32'hC;
        step();
        check("wr2", {mem_we, 19'd0, mem_addr}, {1'b1, 19'd0, 12'd2});
        check("wr2_data", mem_wdata, 32'hC);
        cmd_register = 2; address_register = 1;
        step();
        check("rd_issue", {mem_we, mem_re, 18'd0, mem_addr}, {2'b01, 18'd0, 12'd1});
        cmd_register = 0;
        step();
        check("rd_not_yet", data_o_register, 0);
        step();
        check("rd_data", data_o_register, 32'hB);
        step();
        check("rd_hold", data_o_register, 32'hB);

        // eng_done outside RUNNING is ignored
        eng_done = 1; eng_accept = 1;
        step();
        check("done_idle", status_register, 0);
        eng_done = 0; eng_accept = 0;

        // START held 4 cycles launches once; done after 20 running cycles
        start_cc_pointer_register = 32'h10; end_cc_pointer_register = 32'h1F;
        snap = start_pulses;
        cmd_register = 3;
        step();
        check("start_pulse", {31'd0, eng_start}, 1);
        check("start_status", status_register, 1);
        check("start_ptr", eng_start_ptr, 32'h10);
        check("end_ptr", eng_end_ptr, 32'h1F);
        steps(3);
        cmd_register = 0;
        steps(16);
        check("start_once", start_pulses - snap, 1);
        eng_done = 1; eng_accept = 1;
        step();
        eng_done = 0; eng_accept = 0;
        check("accepted", status_register, 2);
        cmd_register = 5;
        step();
        cmd_register = 0;
        check("elapsed20", data_o_register, 20);

        // Memory commands ignored while RUNNING; reject path
        cmd_register = 3;
        step();
        check("run2_status", status_register, 1);
        cmd_register = 1; address_register = 5; data_in_register = 32'h55;
        step();
        check("run_no_we", {31'd0, mem_we}, 0);
        cmd_register = 2;
        step();
        check("run_no_re", {31'd0, mem_re}, 0);
        cmd_register = 0;
        steps(2);
        check("run_data_hold", data_o_register, 20);
        eng_done = 1; eng_accept = 0;
        step();
        eng_done = 0;
        check("rejected", status_register, 3);

        // RESET beats eng_done in the same cycle
        cmd_register = 3;
        step();
        cmd_register = 0;
        steps(3);
        snap = abort_pulses;
        cmd_register = 4; eng_done = 1; eng_accept = 1;
        step();
        cmd_register = 0; eng_done = 0; eng_accept = 0;
        check("reset_status", status_register, 0);
        check("reset_abort", {31'd0, eng_abort}, 1);
        cmd_register = 5;
        step();
        cmd_register = 0;
        check("abort_once", abort_pulses - snap, 1);
        check("reset_cnt", data_o_register, 0);

        // Run-time limit
        cmd_register = 3;
        step();
        cmd_register = 0;
        snap = abort_pulses;
        steps(7);
        check("tmo_pre", status_register, 1);
        step();
`ifdef CMD_TIMEOUT_EN
        check("tmo_status", status_register, 4);
        check("tmo_abort", {31'd0, eng_abort}, 1);
        cmd_register = 3;
        step();
        cmd_register = 0;
        check("tmo_restart", status_register, 1);
`else
        check("no_tmo_status", status_register, 1);
        check("no_tmo_abort", abort_pulses - snap, 0);
`endif

        // Reset asserted mid-run abandons without abort
        steps(2);
        snap = abort_pulses;
        rst = 1'b0;
        #1;
        check("mid_rst_status", status_register, 0);
        check("mid_rst_data_o", data_o_register, 0);
        check("mid_rst_ptrs", eng_start_ptr | eng_end_ptr, 0);
        check("mid_rst_ctl", {28'd0, eng_start, eng_abort, mem_we, mem_re}, 0);
        steps(2);
        rst = 1'b1;
        steps(2);
        check("mid_rst_no_abort", abort_pulses - snap, 0);
        check("post_rst_status", status_register, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
